output_port_buf: RTL

OUTPUT_PORT_BUF -- requirements
Module: output_port_buf

---
 rtl/output_port_buf_if.sv | 57 +++++
 rtl/output_port_buf.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/output_port_buf_if.sv
// -----------------------------------------------------------------------------
// output_port_buf_if
//
// Bundles the data and flow-control signals of one output-port buffer.
//
// Direction split:
//   master : the leaf and the converge stage. They drive din/din_valid,
//            rd_sel and the credit update.
//   slave  : output_port_buf. It drives din_ready, packet_out and empty.
//
// Signals:
//   din          [PACKET_BITS-2:0]  payload from the leaf
//   din_valid                       din is valid
//   din_ready                       buffer can accept din
//   rd_sel                          poll strobe from the converge stage
//   packet_out   [PACKET_BITS-1:0]  popped packet {valid, payload}
//   empty                           nothing sendable (no data or no credit)
//   credit_load                     freespace update strobe
//   credit_value [CREDIT_BITS-1:0]  absolute freespace reported downstream
// -----------------------------------------------------------------------------
interface output_port_buf_if #(
  parameter int PACKET_BITS = 97,
  parameter int CREDIT_BITS = 8
);

  logic [PACKET_BITS-2:0] din;
  logic                   din_valid;
  logic                   din_ready;
  logic                   rd_sel;
  logic [PACKET_BITS-1:0] packet_out;
  logic                   empty;
  logic                   credit_load;
  logic [CREDIT_BITS-1:0] credit_value;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    output rd_sel,
    input  packet_out,
    input  empty,
    output credit_load,
    output credit_value
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    input  rd_sel,
    output packet_out,
    output empty,
    input  credit_load,
    input  credit_value
  );

endinterface

// File: rtl/output_port_buf.sv
// -----------------------------------------------------------------------------
// output_port_buf
//
// Credit-gated output buffer for one output port. Packets from the leaf are
// queued in a 2**FIFO_ASIZE deep FIFO. The converge stage polls the port with
// rd_sel; a poll that finds both data and credit ("send") pops the head and
// presents {1'b1, head} on packet_out one cycle later. Every other cycle
// packet_out is all zeros, so a valid flag is never held over.
//
// Credit counts free space downstream. Each send consumes one credit;
// credit_load overwrites the counter with an absolute value reported by the
// receiver and takes priority over the decrement of a concurrent send.
// A two-state FSM (SEND / STALL) tracks whether any credit is left.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        output_port_buf_if.slave (din/din_valid/din_ready, rd_sel,
//              packet_out, empty, credit_load/credit_value)
//   pkt_count  [31:0] sends since reset, wrapping; present only with the
//              optional feature below
//
// Optional feature:
//   OUTPUT_PORT_PKT_COUNT_EN  when defined, adds the pkt_count output and its
//                             counter. When undefined neither exists.
//
// Parameters:
//   PACKET_BITS  width of packet_out; MSB is the valid flag
//   FIFO_ASIZE   log2 of the FIFO depth
//   CREDIT_BITS  width of the credit counter
//   CREDIT_INIT  credit loaded at reset
// -----------------------------------------------------------------------------
module output_port_buf #(
  parameter int PACKET_BITS = 97,
  parameter int FIFO_ASIZE  = 4,
  parameter int CREDIT_BITS = 8,
  parameter int CREDIT_INIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output_port_buf_if.slave      bus
`ifdef OUTPUT_PORT_PKT_COUNT_EN
  ,
  output logic [31:0]           pkt_count
`endif
);

  localparam int DEPTH       = 2 ** FIFO_ASIZE;
  localparam int DATA_BITS   = PACKET_BITS - 1;

  typedef enum logic {
    SEND  = 1'b0,
    STALL = 1'b1
  } credit_state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // that differ only in the wrap bit mean full.
  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [FIFO_ASIZE:0]   wr_ptr;
  logic [FIFO_ASIZE:0]   rd_ptr;
  logic [FIFO_ASIZE-1:0] wr_addr;
  logic [FIFO_ASIZE-1:0] rd_addr;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic                  push;
  logic                  send;

  logic [CREDIT_BITS-1:0] credit;
  logic [CREDIT_BITS-1:0] credit_next;
  credit_state_t          state;
  credit_state_t          state_next;

  logic [PACKET_BITS-1:0] packet_q;

  assign wr_addr    = wr_ptr[FIFO_ASIZE-1:0];
  assign rd_addr    = rd_ptr[FIFO_ASIZE-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_ASIZE] != rd_ptr[FIFO_ASIZE]) &&
                      (wr_addr == rd_addr);

  // Reset clears the pointers, so din_ready reads 1 and empty reads 1 for as
  // long as rst_n is low, without extra gating.
  assign bus.din_ready  = !fifo_full;
  assign bus.empty      = fifo_empty || (credit == '0);
  assign bus.packet_out = packet_q;

  // A write while full is dropped here; the leaf keeps din_valid up and the
  // word is taken once a pop frees a slot.
  assign push = bus.din_valid && !fifo_full;
  assign send = bus.rd_sel && !bus.empty;

  // NOTE: the storage array has no reset; emptiness is defined by the
  // pointers alone, and leaving the array out of the reset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_addr] <= bus.din;
    end
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // Push and pop are independent, so a simultaneous pair leaves the
      // occupancy unchanged and keeps the pushed word.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (send) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: one-cycle pulse per send, zero otherwise
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      packet_q <= '0;
    end else if (send) begin
      packet_q <= {1'b1, mem[rd_addr]};
    end else begin
      packet_q <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Credit counter and SEND/STALL FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    credit_next = credit;
    state_next  = state;

    // A load is absolute and wins over the decrement. When it coincides with
    // a send, the send was granted on the old credit, so its cost is taken
    // from the new value, clamped at zero.
    if (bus.credit_load) begin
      if (send) begin
        credit_next = (bus.credit_value == '0) ? '0
                    : bus.credit_value - CREDIT_BITS'(1);
      end else begin
        credit_next = bus.credit_value;
      end
    end else if (send) begin
      // send implies credit > 0, so this never wraps.
      credit_next = credit - CREDIT_BITS'(1);
    end

    unique case (state)
      SEND: begin
        if (credit_next == '0) begin
          state_next = STALL;
        end
      end
      STALL: begin
        if (credit_next != '0) begin
          state_next = SEND;
        end
      end
      default: state_next = SEND;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= CREDIT_BITS'(CREDIT_INIT);
      state  <= (CREDIT_INIT == 0) ? STALL : SEND;
    end else begin
      credit <= credit_next;
      state  <= state_next;
    end
  end

`ifdef OUTPUT_PORT_PKT_COUNT_EN
  // ---------------------------------------------------------------------------
  // Sent-packet counter, free-running modulo 2**32
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
    end else if (send) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end
`endif

endmodule
